// File: rtl/vector_mem_pkg.sv
// vector_mem_pkg
//   Shared types and constants for the vector memory stage.
//   - state_e : access FSM states (IDLE, BUSY, DONE)
//   - kind_e  : latched access kind (scalar/vector, read/write)
//   - WORD_BYTES : byte stride between consecutive bus words
//   - BEAT_W  : beat-index width for the default 8-beat vector access
package vector_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SREAD  = 2'd0,
      SWRITE = 2'd1,
      VREAD  = 2'd2,
      VWRITE = 2'd3
   } kind_e;

   localparam int WORD_BYTES    = 4;
   localparam int DEFAULT_BEATS = 8;

   // Width needed to index 0..beats-1; never narrower than one bit.
   function automatic int beat_idx_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   localparam int BEAT_W = beat_idx_width(DEFAULT_BEATS);

endpackage

// File: rtl/vector_mem_stage_beat_counter.sv
// vec_beat_counter
//   Beat index for a multi-beat bus access.
//   Ports:
//     clk, rst   : clock, asynchronous active-low reset
//     clr        : return the index to 0 (takes priority over inc)
//     inc        : advance the index (one accepted bus beat)
//     last_idx   : index of the final beat of the current access
//     beat       : current beat index
//     last       : current beat is the final one
module vec_beat_counter
   import vector_mem_pkg::*;
#(
   parameter int CW = BEAT_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic [CW-1:0] last_idx,
   output logic [CW-1:0] beat,
   output logic          last
);

   logic [CW-1:0] beat_q;
   logic [CW-1:0] beat_d;

   always_comb begin
      beat_d = beat_q;
      if (clr) begin
         beat_d = '0;
      end else if (inc) begin
         beat_d = beat_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_q <= '0;
      end else begin
         beat_q <= beat_d;
      end
   end

   assign beat = beat_q;
   assign last = (beat_q == last_idx);

endmodule

// File: rtl/vector_mem_stage.sv
// vector_mem_stage
//   Memory-stage bus sequencer for scalar and vector loads/stores. A request
//   seen in IDLE is latched and replayed on a word bus, one beat per accepted
//   mem_ready; the pipeline is stalled until the DONE cycle.
//   Ports:
//     clk, rst                 : clock, asynchronous active-low reset
//     MemReadM/MemWriteM       : scalar load/store request
//     VecMemReadM/VecMemWriteM : vector load/store request
//     ALUResultM               : byte address (scalar address or vector base)
//     WriteDataM/WriteDataVM   : scalar/vector store data
//     mem_req/mem_we/mem_addr/mem_wdata : bus beat request
//     mem_ready/mem_rdata      : bus beat acceptance and read data
//     ReadDataM/ReadDataVM     : scalar/vector load results
//     StallM                   : access in progress, hold the pipeline
module vector_mem_stage
   import vector_mem_pkg::*;
#(
   parameter int N     = 32,
   parameter int V     = 256,
   parameter int BEATS = V / N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         MemReadM,
   input  logic         MemWriteM,
   input  logic         VecMemReadM,
   input  logic         VecMemWriteM,
   input  logic [N-1:0] ALUResultM,
   input  logic [N-1:0] WriteDataM,
   input  logic [V-1:0] WriteDataVM,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic         mem_ready,
   input  logic [N-1:0] mem_rdata,
   output logic [N-1:0] ReadDataM,
   output logic [V-1:0] ReadDataVM,
   output logic         StallM
);

   localparam int CW = beat_idx_width(BEATS);

   state_e        state_q, state_d;
   kind_e         kind_q, kind_d;
   logic [N-1:0]  addr_q, addr_d;
   logic [N-1:0]  wdata_q, wdata_d;
   logic [V-1:0]  wdata_v_q, wdata_v_d;
   logic [N-1:0]  rdata_s_q, rdata_s_d;
   logic [V-1:0]  rdata_v_q, rdata_v_d;

   logic          req;
   logic          is_vec;
   logic          is_store;
   logic          cnt_clr;
   logic          cnt_inc;
   logic          last_beat;
   logic [CW-1:0] beat;
   logic [CW-1:0] last_idx;
   logic [N-1:0]  wlane [BEATS];

   assign req      = MemReadM | MemWriteM | VecMemReadM | VecMemWriteM;
   assign is_vec   = (kind_q == VREAD) || (kind_q == VWRITE);
   assign is_store = (kind_q == SWRITE) || (kind_q == VWRITE);
   assign last_idx = is_vec ? CW'(BEATS - 1) : '0;

   // Lane view of the latched vector store data, lane 0 in the low bits.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
         assign wlane[gi] = wdata_v_q[gi*N +: N];
      end
   endgenerate

   vec_beat_counter #(
      .CW (CW)
   ) u_beat_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .last_idx (last_idx),
      .beat     (beat),
      .last     (last_beat)
   );

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wdata_v_d = wdata_v_q;
      rdata_s_d = rdata_s_q;
      rdata_v_d = rdata_v_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;

      case (state_q)
         IDLE: begin
            // Keep the counter parked at 0 so BUSY always starts on lane 0.
            cnt_clr = 1'b1;
            if (req) begin
               state_d   = BUSY;
               addr_d    = ALUResultM & ~N'(WORD_BYTES - 1);
               wdata_d   = WriteDataM;
               wdata_v_d = WriteDataVM;
               // Vector beats scalar; within a kind, write beats read.
               kind_d    = VecMemWriteM ? VWRITE :
                           VecMemReadM  ? VREAD  :
                           MemWriteM    ? SWRITE : SREAD;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               cnt_inc = 1'b1;
               if (kind_q == SREAD) begin
                  rdata_s_d = mem_rdata;
               end
               if (kind_q == VREAD) begin
                  for (int i = 0; i < BEATS; i++) begin
                     if (beat == CW'(i)) begin
                        rdata_v_d[i*N +: N] = mem_rdata;
                     end
                  end
               end
               if (last_beat) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         kind_q    <= SREAD;
         addr_q    <= '0;
         wdata_q   <= '0;
         wdata_v_q <= '0;
         rdata_s_q <= '0;
         rdata_v_q <= '0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wdata_v_q <= wdata_v_d;
         rdata_s_q <= rdata_s_d;
         rdata_v_q <= rdata_v_d;
      end
   end

   // Bus outputs are decoded straight from registered state, so an
   // asynchronous reset drops mem_req within the same cycle.
   assign mem_req    = (state_q == BUSY);
   assign mem_we     = mem_req && is_store;
   assign mem_addr   = addr_q + (N'(beat) * N'(WORD_BYTES));
   assign mem_wdata  = is_vec ? wlane[beat] : wdata_q;
   assign ReadDataM  = rdata_s_q;
   assign ReadDataVM = rdata_v_q;
   assign StallM     = (state_q == BUSY) || ((state_q == IDLE) && req);

endmodule

// File: tb/tb_vector_mem_stage.sv
module tb_vector_mem_stage;

   localparam int N = 32;
   localparam int V = 256;
   localparam int BEATS = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         MemReadM, MemWriteM, VecMemReadM, VecMemWriteM;
   logic [N-1:0] ALUResultM, WriteDataM;
   logic [V-1:0] WriteDataVM;
   logic         mem_req, mem_we, mem_ready;
   logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [N-1:0] ReadDataM;
   logic [V-1:0] ReadDataVM;
   logic         StallM;

   vector_mem_stage #(.N(N), .V(V), .BEATS(BEATS)) dut (
      .clk          (clk),
      .rst          (rst),
      .MemReadM     (MemReadM),
      .MemWriteM    (MemWriteM),
      .VecMemReadM  (VecMemReadM),
      .VecMemWriteM (VecMemWriteM),
      .ALUResultM   (ALUResultM),
      .WriteDataM   (WriteDataM),
      .WriteDataVM  (WriteDataVM),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .ReadDataM    (ReadDataM),
      .ReadDataVM   (ReadDataVM),
      .StallM       (StallM)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic [31:0]  rs;
      logic [255:0] rv;
      int           stall;
   } res_t;

   beat_t beat_q[$];
   res_t  res_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference view of the load-result registers.
   logic [31:0]  m_rs = '0;
   logic [255:0] m_rv = '0;

   // Bus slave behaviour.
   int          ready_mode = 0;   // 0: always ready, 1: toggle 1,0,1,..., 2: random
   int          rd_mode    = 0;   // 0: hash of address, 1: constant, 2: word index from base
   logic        tog        = 1'b1;
   logic [31:0] const_val  = '0;
   logic [31:0] cur_base   = '0;
   logic [31:0] salt       = 32'h1234_5678;

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      case (rd_mode)
         1:       return const_val;
         2:       return (a - cur_base) >> 2;
         default: return (a ^ salt) * 32'h9E37_79B1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus slave: responds shortly after each rising edge.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: mem_ready = 1'b1;
            1: begin mem_ready = tog; tog = ~tog; end
            default: mem_ready = 1'($urandom_range(0, 1));
         endcase
         mem_rdata = rd_fn(mem_addr);
      end
   end

   // Monitor: checks every presented bus beat and every completed access.
   initial begin
      int   run;
      logic prev;
      beat_t b;
      res_t  r;
      run  = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            run  = 0;
            prev = 1'b0;
         end else begin
            if (mem_req) begin
               if (beat_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got addr %h expected no beat", mem_addr);
               end else begin
                  b = beat_q[0];
                  chk("beat_addr", 256'(mem_addr), 256'(b.addr));
                  chk("beat_we", 256'(mem_we), 256'(b.we));
                  chk("beat_wdata", 256'(mem_wdata), 256'(b.wdata));
                  if (mem_ready) void'(beat_q.pop_front());
               end
            end
            if (StallM) begin
               run++;
            end else if (prev) begin
               if (res_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_done: got completion expected none");
               end else begin
                  r = res_q.pop_front();
                  chk("ReadDataM", 256'(ReadDataM), 256'(r.rs));
                  chk("ReadDataVM", ReadDataVM, r.rv);
                  chk("done_mem_req", 256'(mem_req), 256'(0));
                  chk("beats_left", 256'(beat_q.size()), 256'(0));
                  if (r.stall >= 0) chk("stall_cycles", 256'(run), 256'(r.stall));
               end
               run = 0;
            end
            prev = StallM;
         end
      end
   end

   task automatic clear_inputs();
      MemReadM     = 1'b0;
      MemWriteM    = 1'b0;
      VecMemReadM  = 1'b0;
      VecMemWriteM = 1'b0;
      ALUResultM   = '0;
      WriteDataM   = '0;
      WriteDataVM  = '0;
   endtask

   // rq = {VecMemWriteM, VecMemReadM, MemWriteM, MemReadM}. Returns one cycle
   // after the request was presented (access now underway).
   task automatic start_req(input logic [3:0] rq, input logic [31:0] a, input logic [31:0] wd,
                            input logic [255:0] wdv, input int rmode, input bit junk);
      logic        vec, wr;
      int          nb;
      logic [31:0] base, ba;
      beat_t       b;
      res_t        r;
      if (rq[3])      begin vec = 1'b1; wr = 1'b1; end
      else if (rq[2]) begin vec = 1'b1; wr = 1'b0; end
      else if (rq[1]) begin vec = 1'b0; wr = 1'b1; end
      else            begin vec = 1'b0; wr = 1'b0; end
      base = a & 32'hFFFF_FFFC;
      nb   = vec ? BEATS : 1;
      @(posedge clk);
      #1;
      ready_mode   = rmode;
      tog          = 1'b1;
      cur_base     = base;
      VecMemWriteM = rq[3];
      VecMemReadM  = rq[2];
      MemWriteM    = rq[1];
      MemReadM     = rq[0];
      ALUResultM   = a;
      WriteDataM   = wd;
      WriteDataVM  = wdv;
      for (int i = 0; i < nb; i++) begin
         ba      = base + 32'(4 * i);
         b.addr  = ba;
         b.we    = wr;
         b.wdata = vec ? wdv[32*i +: 32] : wd;
         beat_q.push_back(b);
         if (!wr) begin
            if (vec) m_rv[32*i +: 32] = rd_fn(ba);
            else     m_rs = rd_fn(ba);
         end
      end
      r.rs    = m_rs;
      r.rv    = m_rv;
      r.stall = (rmode == 0) ? 1 + nb : -1;
      res_q.push_back(r);
      @(posedge clk);
      #1;
      if (junk) begin
         {VecMemWriteM, VecMemReadM, MemWriteM, MemReadM} = 4'($urandom_range(0, 15));
         ALUResultM  = $urandom;
         WriteDataM  = $urandom;
         WriteDataVM = {8{$urandom}};
      end else begin
         clear_inputs();
      end
   endtask

   task automatic finish_req();
      int budget;
      budget = 0;
      while (StallM === 1'b1 && budget < 300) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (budget >= 300) begin
         n_cmp++;
         n_bad++;
         $display("FAIL access_timeout: got StallM stuck high expected completion within 300 cycles");
      end
      clear_inputs();
   endtask

   task automatic do_req(input logic [3:0] rq, input logic [31:0] a, input logic [31:0] wd,
                         input logic [255:0] wdv, input int rmode, input bit junk);
      start_req(rq, a, wd, wdv, rmode, junk);
      finish_req();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0]  a;
      logic [255:0] wdv;
      rst = 1'b0;
      clear_inputs();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", 256'(mem_req), 256'(0));
      chk("rst_mem_we", 256'(mem_we), 256'(0));
      chk("rst_mem_addr", 256'(mem_addr), 256'(0));
      chk("rst_mem_wdata", 256'(mem_wdata), 256'(0));
      chk("rst_ReadDataM", 256'(ReadDataM), 256'(0));
      chk("rst_ReadDataVM", ReadDataVM, 256'(0));
      chk("rst_StallM_idle", 256'(StallM), 256'(0));
      MemReadM = 1'b1;
      #1;
      chk("rst_StallM_req", 256'(StallM), 256'(1));
      MemReadM = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Scalar load, constant read data.
      rd_mode   = 1;
      const_val = 32'hDEAD_BEEF;
      do_req(4'b0001, 32'h0000_0100, '0, '0, 0, 1'b0);

      // Vector load, read data = beat index.
      rd_mode = 2;
      do_req(4'b0100, 32'h0000_2000, '0, '0, 0, 1'b0);

      // Vector store with toggling ready.
      rd_mode = 0;
      wdv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_req(4'b1000, 32'h0000_3000, '0, wdv, 1, 1'b0);

      // Unaligned base wrapping past the top of the address space.
      do_req(4'b0100, 32'hFFFF_FFF3, '0, '0, 0, 1'b0);

      // Simultaneous vector store and scalar load.
      wdv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_req(4'b1001, 32'h0000_0400, 32'hCAFE_F00D, wdv, 0, 1'b0);

      // Reset in the middle of a vector load.
      rd_mode = 2;
      start_req(4'b0100, 32'h0000_5000, '0, '0, 0, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      beat_q.delete();
      res_q.delete();
      m_rs = '0;
      m_rv = '0;
      #1;
      chk("abort_mem_req", 256'(mem_req), 256'(0));
      chk("abort_StallM", 256'(StallM), 256'(0));
      chk("abort_mem_addr", 256'(mem_addr), 256'(0));
      chk("abort_ReadDataVM", ReadDataVM, 256'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_mem_req", 256'(mem_req), 256'(0));
      rd_mode = 0;
      do_req(4'b0001, 32'h0000_0080, '0, '0, 0, 1'b0);

      // Randomized mix with garbage requests during the access.
      for (int t = 0; t < 40; t++) begin
         salt = $urandom;
         a    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) : $urandom;
         wdv  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         do_req(4'($urandom_range(1, 15)), a, $urandom, wdv, $urandom_range(0, 2), 1'b1);
      end

      repeat (3) @(posedge clk);
      chk("beat_queue_empty", 256'(beat_q.size()), 256'(0));
      chk("result_queue_empty", 256'(res_q.size()), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
